// File: rtl/pic_control_logic_if.sv
// Bus between the 8259A read/write stage, the interrupt pins and the PIC control core.
// slave: control core; master: whatever drives strobes, data, IR and INTA_N.
interface pic_control_logic_if;
  logic [3:0] ICW;
  logic [2:0] OCW;
  logic [7:0] D;
  logic [7:0] IR;
  logic       INTA_N;
  logic       INT;
  logic [7:0] VEC;
  logic       VEC_OE;
  logic [1:0] Read_command;
  logic [7:0] IRR;
  logic [7:0] ISR;
  logic [7:0] IMR;

  modport master (
    output ICW, OCW, D, IR, INTA_N,
    input  INT, VEC, VEC_OE, Read_command, IRR, ISR, IMR
  );

  modport slave (
    input  ICW, OCW, D, IR, INTA_N,
    output INT, VEC, VEC_OE, Read_command, IRR, ISR, IMR
  );
endinterface

// File: rtl/pic_control_logic.sv
// 8259A control core: IRR/ISR/IMR, rotating priority, INT and the two-pulse INTA vector sequence.
// Writes, IR and INTA_N act SYNC_STAGES+1 cycles after the pin; no backpressure, the host holds strobes/INTA long enough.
module pic_control_logic #(
  parameter int SYNC_STAGES = 2
) (
  input logic               CLK,
  input logic               RST_N,
  pic_control_logic_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACK1, WAIT2, ACK2} state_t;

  logic [SYNC_STAGES-1:0][3:0] icw_sync;
  logic [SYNC_STAGES-1:0][2:0] ocw_sync;
  logic [SYNC_STAGES-1:0][7:0] d_sync;
  logic [SYNC_STAGES-1:0][7:0] ir_sync;
  logic [SYNC_STAGES-1:0]      inta_sync;

  logic [3:0] icw_q;
  logic [2:0] ocw_q;
  logic [7:0] ir_q;
  logic       inta_q;

  logic [7:0] irr, isr, imr, cas;
  logic [4:0] t;
  logic [2:0] l;
  logic       ltim, ic4, aeoi, rot_aeoi;
  logic [1:0] read_cmd;
  state_t     state;
  logic [2:0] level;
  logic       spurious;
  logic [7:0] vec;
  logic       vec_oe;
  logic       int_q;

  logic [3:0] icw_s, icw_c;
  logic [2:0] ocw_s, ocw_c;
  logic [7:0] d_s, ir_s;
  logic       inta_s, inta_fall, inta_rise;
  logic [7:0] cand;
  logic       cand_f, isr_f, int_now;
  logic [2:0] cand_lvl, isr_lvl, cand_rank, isr_rank;
  logic       ack_real, ack2_done;
  logic [7:0] irr_n, isr_n;
  logic       unused_cas;

  // Scan from lowest to highest priority so the highest set bit is the last one kept.
  function automatic logic [3:0] highest(input logic [7:0] v, input logic [2:0] low);
    logic [2:0] idx;
    logic [3:0] r;
    r = 4'b0;
    for (int i = 8; i >= 1; i--) begin
      idx = low + i[2:0];
      if (v[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign icw_s  = icw_sync[SYNC_STAGES-1];
  assign ocw_s  = ocw_sync[SYNC_STAGES-1];
  assign d_s    = d_sync[SYNC_STAGES-1];
  assign ir_s   = ir_sync[SYNC_STAGES-1];
  assign inta_s = inta_sync[SYNC_STAGES-1];

  assign icw_c     = icw_s & ~icw_q;
  assign ocw_c     = ocw_s & ~ocw_q;
  assign inta_fall = inta_q & ~inta_s;
  assign inta_rise = ~inta_q & inta_s;

  assign cand = irr & ~imr;
  assign {cand_f, cand_lvl} = highest(cand, l);
  assign {isr_f, isr_lvl}   = highest(isr, l);
  assign cand_rank = cand_lvl - l - 3'd1;
  assign isr_rank  = isr_lvl - l - 3'd1;
  assign int_now   = cand_f && (!isr_f || (cand_rank < isr_rank));

  assign ack_real  = (state == IDLE) && inta_fall && int_now;
  assign ack2_done = (state == ACK2) && inta_rise;

  // Cascade is not modelled; ICW3 is only held.
  assign unused_cas = ^cas;

  always_comb begin
    irr_n = ltim ? ir_s : ((irr | (ir_s & ~ir_q)) & ir_s);
    if (ack_real) irr_n[cand_lvl] = 1'b0;

    isr_n = isr;
    if (ocw_c[1]) begin
      case (d_s[7:5])
        3'b001, 3'b101: if (isr_f) isr_n[isr_lvl] = 1'b0;
        3'b011, 3'b111: isr_n[d_s[2:0]] = 1'b0;
        default: ;
      endcase
    end
    if (ack2_done && aeoi && !spurious) isr_n[level] = 1'b0;
    // A same-cycle acknowledge set wins over any EOI clear.
    if (ack_real) isr_n[cand_lvl] = 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      icw_sync  <= '0;
      ocw_sync  <= '0;
      d_sync    <= '0;
      ir_sync   <= '0;
      inta_sync <= '1;
      icw_q     <= '0;
      ocw_q     <= '0;
      ir_q      <= '0;
      inta_q    <= 1'b1;
      irr       <= '0;
      isr       <= '0;
      imr       <= '0;
      cas       <= '0;
      t         <= '0;
      l         <= 3'd7;
      ltim      <= 1'b0;
      ic4       <= 1'b0;
      aeoi      <= 1'b0;
      rot_aeoi  <= 1'b0;
      read_cmd  <= 2'b10;
      state     <= IDLE;
      level     <= '0;
      spurious  <= 1'b0;
      vec       <= '0;
      vec_oe    <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      icw_sync  <= {icw_sync[SYNC_STAGES-2:0], bus.ICW};
      ocw_sync  <= {ocw_sync[SYNC_STAGES-2:0], bus.OCW};
      d_sync    <= {d_sync[SYNC_STAGES-2:0], bus.D};
      ir_sync   <= {ir_sync[SYNC_STAGES-2:0], bus.IR};
      inta_sync <= {inta_sync[SYNC_STAGES-2:0], bus.INTA_N};
      icw_q     <= icw_s;
      ocw_q     <= ocw_s;
      ir_q      <= ir_s;
      inta_q    <= inta_s;

      if (icw_c[0]) begin
        ltim     <= d_s[3];
        ic4      <= d_s[0];
        imr      <= '0;
        isr      <= '0;
        irr      <= '0;
        l        <= 3'd7;
        rot_aeoi <= 1'b0;
        aeoi     <= 1'b0;
        read_cmd <= 2'b10;
        state    <= IDLE;
        vec_oe   <= 1'b0;
        int_q    <= 1'b0;
      end else begin
        irr   <= irr_n;
        isr   <= isr_n;
        int_q <= int_now;

        if (icw_c[1]) t <= d_s[7:3];
        if (icw_c[2]) cas <= d_s;
        if (icw_c[3] && ic4) aeoi <= d_s[1];
        if (ocw_c[0]) imr <= d_s;
        if (ocw_c[1]) begin
          case (d_s[7:5])
            3'b101:         if (isr_f) l <= isr_lvl;
            3'b111, 3'b110: l <= d_s[2:0];
            3'b100:         rot_aeoi <= 1'b1;
            3'b000:         rot_aeoi <= 1'b0;
            default: ;
          endcase
        end
        if (ocw_c[2] && d_s[1]) read_cmd <= {1'b1, d_s[0]};

        case (state)
          IDLE: if (inta_fall) begin
            level    <= int_now ? cand_lvl : 3'd7;
            spurious <= !int_now;
            state    <= ACK1;
          end
          ACK1: if (inta_rise) state <= WAIT2;
          WAIT2: if (inta_fall) begin
            vec    <= {t, level};
            vec_oe <= 1'b1;
            state  <= ACK2;
          end
          ACK2: if (inta_rise) begin
            vec_oe <= 1'b0;
            if (aeoi && !spurious && rot_aeoi) l <= level;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.INT          = int_q;
  assign bus.VEC          = vec;
  assign bus.VEC_OE       = vec_oe;
  assign bus.Read_command = read_cmd;
  assign bus.IRR          = irr;
  assign bus.ISR          = isr;
  assign bus.IMR          = imr;

endmodule

// File: tb/tb_pic_control_logic.sv
// Directed bench for pic_control_logic: init, acknowledge, nesting/EOI, AEOI rotation, spurious, OCW3, re-init, reset.
module tb_pic_control_logic;
  localparam int S = 2;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  int checks = 0;
  int errors = 0;

  pic_control_logic_if bus();

  pic_control_logic #(.SYNC_STAGES(S)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic wr_icw(input int n, input logic [7:0] d);
    bus.D   = d;
    bus.ICW = 4'b0001 << n;
    cyc(S + 3);
    bus.ICW = '0;
    cyc(2);
  endtask

  task automatic wr_ocw(input int n, input logic [7:0] d);
    bus.D   = d;
    bus.OCW = 3'b001 << n;
    cyc(S + 3);
    bus.OCW = '0;
    cyc(2);
  endtask

  task automatic inta(input logic lvl);
    bus.INTA_N = lvl;
    cyc(S + 2);
  endtask

  task automatic set_ir(input logic [7:0] v);
    bus.IR = v;
    cyc(S + 3);
  endtask

  initial begin
    bus.ICW = '0;
    bus.OCW = '0;
    bus.D = '0;
    bus.IR = '0;
    bus.INTA_N = 1'b1;
    cyc(3);
    RST_N = 1'b1;
    cyc(4);

    // Reset state
    chk("rst_int",    {7'b0, bus.INT}, 8'h00);
    chk("rst_imr",    bus.IMR, 8'h00);
    chk("rst_isr",    bus.ISR, 8'h00);
    chk("rst_irr",    bus.IRR, 8'h00);
    chk("rst_rdcmd",  {6'b0, bus.Read_command}, 8'h02);
    chk("rst_vec_oe", {7'b0, bus.VEC_OE}, 8'h00);
    chk("rst_vec",    bus.VEC, 8'h00);

    // Basic acknowledge of IR2
    wr_icw(0, 8'h13);
    wr_icw(1, 8'h40);
    wr_icw(3, 8'h01);
    wr_ocw(0, 8'hFB);
    chk("basic_imr", bus.IMR, 8'hFB);
    set_ir(8'h04);
    chk("basic_irr", bus.IRR, 8'h04);
    chk("basic_int", {7'b0, bus.INT}, 8'h01);
    inta(1'b0);
    chk("basic_isr1",   bus.ISR, 8'h04);
    chk("basic_irr1",   bus.IRR, 8'h00);
    chk("basic_int1",   {7'b0, bus.INT}, 8'h00);
    chk("basic_vecoe1", {7'b0, bus.VEC_OE}, 8'h00);
    inta(1'b1);
    inta(1'b0);
    chk("basic_vecoe2", {7'b0, bus.VEC_OE}, 8'h01);
    chk("basic_vec",    bus.VEC, 8'h42);
    inta(1'b1);
    chk("basic_vecoe3", {7'b0, bus.VEC_OE}, 8'h00);
    chk("basic_isr2",   bus.ISR, 8'h04);
    chk("basic_int2",   {7'b0, bus.INT}, 8'h00);
    set_ir(8'h00);

    // Nesting: IR5 masked, IR0 outranks in-service IR2
    wr_ocw(0, 8'h20);
    set_ir(8'h20);
    chk("nest_irr5", bus.IRR, 8'h20);
    chk("nest_int5", {7'b0, bus.INT}, 8'h00);
    set_ir(8'h21);
    chk("nest_int0", {7'b0, bus.INT}, 8'h01);
    inta(1'b0);
    chk("nest_isr", bus.ISR, 8'h05);
    chk("nest_irr", bus.IRR, 8'h20);
    inta(1'b1);
    inta(1'b0);
    chk("nest_vec", bus.VEC, 8'h40);
    inta(1'b1);
    wr_ocw(1, 8'h20);
    chk("nest_ns_eoi", bus.ISR, 8'h04);
    wr_ocw(1, 8'h62);
    chk("nest_sp_eoi", bus.ISR, 8'h00);
    chk("nest_masked_int", {7'b0, bus.INT}, 8'h00);
    set_ir(8'h00);

    // AEOI with rotation
    wr_icw(3, 8'h03);
    wr_ocw(1, 8'h80);
    wr_ocw(0, 8'h00);
    set_ir(8'h08);
    chk("aeoi_int", {7'b0, bus.INT}, 8'h01);
    inta(1'b0);
    chk("aeoi_isr_set", bus.ISR, 8'h08);
    inta(1'b1);
    inta(1'b0);
    chk("aeoi_vec3", bus.VEC, 8'h43);
    inta(1'b1);
    chk("aeoi_isr_clr", bus.ISR, 8'h00);
    set_ir(8'h00);
    set_ir(8'h18);
    chk("rot_irr", bus.IRR, 8'h18);
    chk("rot_int", {7'b0, bus.INT}, 8'h01);
    inta(1'b0);
    inta(1'b1);
    inta(1'b0);
    chk("rot_vec4", bus.VEC, 8'h44);
    inta(1'b1);
    chk("rot_isr", bus.ISR, 8'h00);
    chk("rot_irr_left", bus.IRR, 8'h08);
    set_ir(8'h00);
    wr_ocw(1, 8'h00);

    // Spurious acknowledge with IR1 in service, then OCW3
    wr_icw(3, 8'h01);
    set_ir(8'h02);
    inta(1'b0);
    inta(1'b1);
    inta(1'b0);
    chk("sp_vec1", bus.VEC, 8'h41);
    inta(1'b1);
    chk("sp_isr1", bus.ISR, 8'h02);
    set_ir(8'h00);
    set_ir(8'h01);
    chk("sp_int_on", {7'b0, bus.INT}, 8'h01);
    set_ir(8'h00);
    chk("sp_irr_off", bus.IRR, 8'h00);
    chk("sp_int_off", {7'b0, bus.INT}, 8'h00);
    inta(1'b0);
    inta(1'b1);
    inta(1'b0);
    chk("sp_vec7", bus.VEC, 8'h47);
    inta(1'b1);
    chk("sp_isr", bus.ISR, 8'h02);
    wr_ocw(2, 8'h0B);
    chk("ocw3_isr_sel", {6'b0, bus.Read_command}, 8'h03);
    wr_ocw(2, 8'h08);
    chk("ocw3_keep", {6'b0, bus.Read_command}, 8'h03);

    // Re-initialization between the two INTA pulses
    wr_ocw(0, 8'hF0);
    set_ir(8'h01);
    chk("reinit_int", {7'b0, bus.INT}, 8'h01);
    inta(1'b0);
    chk("reinit_isr_set", bus.ISR, 8'h03);
    inta(1'b1);
    wr_icw(0, 8'h13);
    chk("reinit_isr", bus.ISR, 8'h00);
    chk("reinit_imr", bus.IMR, 8'h00);
    chk("reinit_irr", bus.IRR, 8'h00);
    chk("reinit_rdcmd", {6'b0, bus.Read_command}, 8'h02);
    inta(1'b0);
    chk("reinit_vecoe", {7'b0, bus.VEC_OE}, 8'h00);
    inta(1'b1);

    // Asynchronous reset while the vector is being driven
    wr_ocw(0, 8'h55);
    chk("pre_rst_imr", bus.IMR, 8'h55);
    inta(1'b0);
    chk("pre_rst_vecoe", {7'b0, bus.VEC_OE}, 8'h01);
    chk("pre_rst_vec", bus.VEC, 8'h47);
    RST_N = 1'b0;
    #1;
    chk("arst_vecoe", {7'b0, bus.VEC_OE}, 8'h00);
    chk("arst_vec",   bus.VEC, 8'h00);
    chk("arst_imr",   bus.IMR, 8'h00);
    bus.INTA_N = 1'b1;
    bus.IR = 8'h00;
    cyc(2);
    RST_N = 1'b1;
    cyc(4);
    chk("post_rst_int",   {7'b0, bus.INT}, 8'h00);
    chk("post_rst_rdcmd", {6'b0, bus.Read_command}, 8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pic_control_logic.md
# pic_control_logic

Core of the 8259A model, directly downstream of the read/write stage. It consumes that stage's one-hot ICW/OCW write strobes and data bus and holds the IRR, ISR and IMR registers. It resolves priority, drives INT, and runs the two-pulse INTA sequence that places the 8086-mode vector on the bus. It also returns the OCW3 read selection (`Read_command`) and the IRR/ISR/IMR values to the read/write stage.

## Interface
- `SYNC_STAGES`, 2, number of flip-flop stages synchronizing ICW, OCW, D, IR and INTA_N into CLK (minimum 2).

- `CLK` in 1: single clock; all state changes on its rising edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `ICW` in 4: one-hot write strobes for ICW1..ICW4 from the read/write stage; level while WR is low.
- `OCW` in 3: one-hot write strobes for OCW1..OCW3.
- `D` in 8: data bus; valid while a strobe is high.
- `IR` in 8: asynchronous interrupt requests IR0..IR7.
- `INTA_N` in 1: interrupt acknowledge, active-low, asynchronous.
- `INT` out 1: interrupt request to the CPU.
- `VEC` out 8: vector byte, {T[7:3], level[2:0]}.
- `VEC_OE` out 1: high while VEC is to be driven onto the bus.
- `Read_command` out 2: 2'b10 selects IRR, 2'b11 selects ISR.
- `IRR`, `ISR`, `IMR` out 8 each: current register contents.

## Operation
- **Write commit.** A strobe bit that is 0 in the previous synchronized sample and 1 in the current one commits the synchronized D of that cycle.
  - A host write must hold WR low for at least SYNC_STAGES+2 CLK cycles.
- **ICW1.**
  - LTIM = D[3]; IC4 = D[0].
  - IMR, ISR and IRR clear; lowest-priority L = 7; rotate-in-AEOI = 0; AEOI = 0; Read_command = 2'b10.
  - The INTA FSM is forced to IDLE.
- **ICW2.** T = D[7:3].
- **ICW3.** Stored in CAS; no functional effect (cascade is not modelled).
- **ICW4.** AEOI = D[1]. If IC4 = 0, no ICW4 write is expected, and AEOI stays 0.
- **OCW1.** IMR = D.
- **OCW2.** Action depends on D[7:5]:
  - 001: non-specific EOI; clear the highest-priority set ISR bit.
  - 011: specific EOI; clear ISR[D[2:0]].
  - 101: rotate on non-specific EOI; clear that bit and set L to its level.
  - 111: rotate on specific EOI; clear ISR[D[2:0]] and set L = D[2:0].
  - 110: set priority; L = D[2:0].
  - 100: set rotate-in-AEOI = 1.
  - 000: clear rotate-in-AEOI.
  - 010: no operation.
- **OCW3.** If D[1] = 1, Read_command = {1'b1, D[0]}; otherwise Read_command is unchanged. All other bits are ignored.
- **IRR update.**
  - LTIM = 0 (edge mode): bit n sets on a rising edge of synchronized IR[n] and clears when IR[n] is low.
  - LTIM = 1 (level mode): IRR[n] follows synchronized IR[n].
  - In either mode the acknowledged bit clears on the first INTA.
- **Priority.**
  - Order is L+1 (highest) through L (lowest), modulo 8.
  - Candidate = IRR & ~IMR.
  - INT = 1 when the highest-priority candidate outranks the highest-priority set ISR bit, or ISR is empty and a candidate exists.
- **INTA FSM.**
  - **IDLE**, on synchronized INTA_N falling:
    - If INT = 1: latch the winning level, set ISR[level], clear IRR[level] (edge latch included).
    - If INT = 0: spurious; level = 7, ISR unchanged.
    - Go to ACK1.
  - **ACK1**, on INTA_N rising: go to WAIT2.
  - **WAIT2**, on INTA_N falling: go to ACK2; VEC = {T, level}; VEC_OE = 1.
  - **ACK2**, on INTA_N rising: VEC_OE = 0.
    - If AEOI is set and the acknowledge was not spurious, clear ISR[level].
    - If rotate-in-AEOI is also set, L = level.
    - Go to IDLE.
- **Simultaneous events.**
  - An ICW1 commit overrides everything, including an INTA edge in the same cycle.
  - An OCW2 EOI and an INTA ISR set in the same cycle both apply; the set wins if they target the same bit.

## Timing
- **Reset values:** INT = 0, VEC = 8'h00, VEC_OE = 0, Read_command = 2'b10, IRR = ISR = IMR = 8'h00, T = 0, L = 7, LTIM = AEOI = rotate-in-AEOI = 0, FSM = IDLE.
- **Reset mid-sequence:** RST_N low aborts immediately and asynchronously to the values above.
- **Write latency:** a register update is visible 1 CLK after the synchronized strobe edge, i.e. SYNC_STAGES+1 cycles after the raw strobe.
- **IR latency:** an IR rising edge reaches IRR in SYNC_STAGES+1 cycles; INT is registered and follows one cycle later.
- **INTA latency:** each INTA_N edge acts SYNC_STAGES+1 cycles after the raw pin edge.
  - VEC and VEC_OE are registered outputs; VEC is stable for the whole of the ACK2 state.
- **INTA width:** each INTA_N low or high phase must last at least SYNC_STAGES+1 CLK.

## Test plan
- **Reset:** RST_N low, then high, with no writes → INT = 0, IMR = ISR = IRR = 0, Read_command = 2'b10, VEC_OE = 0.
- **Basic acknowledge:** ICW1 = 8'h13, ICW2 = 8'h40, ICW4 = 8'h01, OCW1 = 8'hFB; pulse IR2 → INT = 1; two INTA pulses → VEC = 8'h42 with VEC_OE high only during the second pulse, ISR = 8'h04, IRR = 0, INT = 0.
- **Nesting and EOI:** with ISR[2] set, raise IR0 → INT = 1 (higher priority) while IR5 alone stays masked; OCW2 = 8'h20 → clears ISR[0] first.
- **AEOI with rotation:** ICW4 = 8'h03, OCW2 = 8'h80; acknowledge IR3 → ISR = 0 after the second INTA, L = 3; with IR3 and IR4 pending, IR4 wins.
- **Spurious and OCW3:** IR pulse removed before INTA → VEC = {T, 3'b111}, ISR unchanged; OCW3 = 8'h0B → Read_command = 2'b11; OCW3 = 8'h08 → Read_command unchanged.
- **Re-initialization:** ICW1 written between the two INTA pulses → FSM returns to IDLE, the second pulse produces no VEC_OE, and IMR = ISR = 0.
